// File: rtl/memory_lookup_engine.sv
// rtl/memory_lookup_engine.sv - GET lookup engine scanning the key/value cell array
// Ports: clk/rst (async active-high); req_valid/req_ready/req_key GET request;
// cell_keys/cell_values/cell_used live cell outputs (cell i at [i*W +: W]);
// read_op one-hot read strobe; resp_valid/resp_ready/resp_hit/resp_value/resp_index response.
module memory_lookup_engine #(
  parameter int NUM_CELLS   = 8,
  parameter int KEY_WIDTH   = 8,
  parameter int VALUE_WIDTH = 64,
  localparam int IDX_WIDTH  = $clog2(NUM_CELLS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [KEY_WIDTH-1:0]             req_key,
  input  logic [NUM_CELLS*KEY_WIDTH-1:0]   cell_keys,
  input  logic [NUM_CELLS*VALUE_WIDTH-1:0] cell_values,
  input  logic [NUM_CELLS-1:0]             cell_used,
  output logic [NUM_CELLS-1:0]             read_op,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic                             resp_hit,
  output logic [VALUE_WIDTH-1:0]           resp_value,
  output logic [IDX_WIDTH-1:0]             resp_index
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t                 state;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [IDX_WIDTH-1:0]   idx;
  // Low on the first SCAN cycle, which only screens the reserved key 0;
  // cell comparisons start on the following cycle.
  logic                   armed;

  logic [KEY_WIDTH-1:0]   cell_key_arr   [NUM_CELLS];
  logic [VALUE_WIDTH-1:0] cell_value_arr [NUM_CELLS];

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_unpack
    assign cell_key_arr[i]   = cell_keys[i*KEY_WIDTH +: KEY_WIDTH];
    assign cell_value_arr[i] = cell_values[i*VALUE_WIDTH +: VALUE_WIDTH];
  end

  logic cur_match;
  assign cur_match = cell_used[idx] && (cell_key_arr[idx] == key_q);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CELLS - 1);
  localparam logic [NUM_CELLS-1:0] ONE_HOT0 = NUM_CELLS'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      key_q      <= '0;
      idx        <= '0;
      armed      <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_value <= '0;
      resp_index <= '0;
      read_op    <= '0;
    end else begin
      // read_op is a single-cycle pulse; only a hit re-asserts it below.
      read_op <= '0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            key_q     <= req_key;
            idx       <= '0;
            armed     <= 1'b0;
            req_ready <= 1'b0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (!armed) begin
            if (key_q == '0) begin
              resp_hit   <= 1'b0;
              resp_value <= '0;
              resp_index <= '0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              armed <= 1'b1;
            end
          end else if (cur_match) begin
            resp_hit   <= 1'b1;
            resp_value <= cell_value_arr[idx];
            resp_index <= idx;
            read_op    <= ONE_HOT0 << idx;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (idx == LAST_IDX) begin
            resp_hit   <= 1'b0;
            resp_value <= '0;
            resp_index <= '0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_lookup_engine.sv
// tb/tb_memory_lookup_engine.sv - directed self-checking bench for memory_lookup_engine
module tb_memory_lookup_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_key;
  logic [63:0] cell_keys;
  logic [511:0] cell_values;
  logic [7:0]  cell_used;
  logic [7:0]  read_op;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_hit;
  logic [63:0] resp_value;
  logic [2:0]  resp_index;

  logic [7:0]  keys [8];
  logic [63:0] vals [8];

  int total = 0;
  int bad   = 0;
  int lat;
  int rop_cnt;
  logic [7:0] rop_val;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 8; i++) begin : g_pack
    assign cell_keys[i*8 +: 8]     = keys[i];
    assign cell_values[i*64 +: 64] = vals[i];
  end

  memory_lookup_engine dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_key     (req_key),
    .cell_keys   (cell_keys),
    .cell_values (cell_values),
    .cell_used   (cell_used),
    .read_op     (read_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_hit    (resp_hit),
    .resp_value  (resp_value),
    .resp_index  (resp_index)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic note_rop();
    if (read_op != 8'h00) begin
      rop_cnt++;
      rop_val = read_op;
    end
  endtask

  // Presents a GET at a negedge; lat = number of edges after the accept edge E
  // until resp_valid is seen (sampled at negedges).
  task automatic do_get(input logic [7:0] k);
    @(negedge clk);
    req_key   = k;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat       = 0;
    rop_cnt   = 0;
    rop_val   = 8'h00;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      note_rop();
    end while (!resp_valid && lat < 30);
  endtask

  task automatic accept_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    note_rop();
    resp_ready = 1'b0;
    check("handshake_valid_low", {63'd0, resp_valid}, 64'd0);
    check("handshake_ready_high", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_key    = 8'h14;
    resp_ready = 1'b0;
    cell_used  = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      keys[i] = 8'h11 + 8'(i);
      vals[i] = 64'hA0 + 64'(i);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_hit", {63'd0, resp_hit}, 64'd0);
    check("rst_resp_value", resp_value, 64'd0);
    check("rst_resp_index", {61'd0, resp_index}, 64'd0);
    check("rst_read_op", {56'd0, read_op}, 64'd0);
    req_valid = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {62'd0, req_ready, resp_valid}, 64'd2);

    // Hit at cell 3
    do_get(8'h14);
    check("hit3_latency", 64'(lat), 64'd5);
    check("hit3_hit", {63'd0, resp_hit}, 64'd1);
    check("hit3_index", {61'd0, resp_index}, 64'd3);
    check("hit3_value", resp_value, 64'hA3);
    check("hit3_req_ready", {63'd0, req_ready}, 64'd0);
    accept_resp();
    check("hit3_rop_count", 64'(rop_cnt), 64'd1);
    check("hit3_rop_value", {56'd0, rop_val}, 64'h08);

    // Absent key: full scan miss
    do_get(8'h55);
    check("miss_latency", 64'(lat), 64'd9);
    check("miss_hit", {63'd0, resp_hit}, 64'd0);
    check("miss_value", resp_value, 64'd0);
    check("miss_index", {61'd0, resp_index}, 64'd0);
    accept_resp();
    check("miss_rop_count", 64'(rop_cnt), 64'd0);

    // Duplicate key: lowest index wins
    keys[2] = 8'h33; vals[2] = 64'h22;
    keys[6] = 8'h33; vals[6] = 64'h66;
    do_get(8'h33);
    check("dup_latency", 64'(lat), 64'd4);
    check("dup_hit", {63'd0, resp_hit}, 64'd1);
    check("dup_index", {61'd0, resp_index}, 64'd2);
    check("dup_value", resp_value, 64'h22);
    accept_resp();
    check("dup_rop_value", {56'd0, rop_val}, 64'h04);

    // Matching key in an unused cell is a miss
    keys[1] = 8'h42;
    cell_used[1] = 1'b0;
    do_get(8'h42);
    check("unused_latency", 64'(lat), 64'd9);
    check("unused_hit", {63'd0, resp_hit}, 64'd0);
    accept_resp();
    check("unused_rop_count", 64'(rop_cnt), 64'd0);

    // Reserved key 0: immediate miss
    do_get(8'h00);
    check("key0_latency", 64'(lat), 64'd1);
    check("key0_hit", {63'd0, resp_hit}, 64'd0);
    check("key0_value", resp_value, 64'd0);
    accept_resp();

    // Backpressured hit; a new request is held pending throughout
    do_get(8'h14);
    check("bp_latency", 64'(lat), 64'd5);
    req_key   = 8'h00;
    req_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      note_rop();
      check("bp_valid_held", {63'd0, resp_valid}, 64'd1);
      check("bp_req_ready_low", {63'd0, req_ready}, 64'd0);
      check("bp_data_stable", {resp_value[59:0], resp_hit, resp_index}, {60'hA3, 1'b1, 3'd3});
    end
    check("bp_rop_once", 64'(rop_cnt), 64'd1);
    // Handshake edge must not also accept the pending request
    accept_resp();
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("next_accepted", {62'd0, req_ready, resp_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("next_key0_resp", {62'd0, resp_valid, resp_hit}, 64'd2);
    accept_resp();

    // Reset during SCAN at idx=3
    @(negedge clk);
    req_key   = 8'h55;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", {read_op, 2'd0, req_ready, resp_valid, resp_hit, resp_index}, {8'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0});
    rst = 1'b0;
    rop_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      note_rop();
      check("abort_no_resp", {62'd0, resp_valid, req_ready}, 64'd1);
    end
    check("abort_rop_none", 64'(rop_cnt), 64'd0);
    do_get(8'h11);
    check("after_abort_latency", 64'(lat), 64'd2);
    check("after_abort_hit", {63'd0, resp_hit}, 64'd1);
    check("after_abort_index", {61'd0, resp_index}, 64'd0);
    check("after_abort_value", resp_value, 64'hA0);
    accept_resp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_lookup_engine.md
# memory_lookup_engine

Read-side companion to the key/value memory cells. It accepts a GET request carrying a key and scans the cell array one cell per cycle, comparing against each cell's registered key/used outputs. It returns hit/miss, the stored value and the cell index over a valid/ready response channel, and pulses the matching cell's `read_op`. It sits between the command decoder and the cell array, opposite the write/allocate path.

## Interface
Parameters:
- `NUM_CELLS`, 8: number of memory cells scanned; must be ≥ 2.
- `KEY_WIDTH`, 8: key width, equal to the cell key width.
- `VALUE_WIDTH`, 64: value width, equal to the cell value width.
- `IDX_WIDTH` (localparam) = `$clog2(NUM_CELLS)`.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  GET request valid.
- `req_ready`  out  1  engine can accept a request.
- `req_key`  in  KEY_WIDTH  key to look up.
- `cell_keys`  in  NUM_CELLS*KEY_WIDTH  flattened cell key outputs; cell i is at bits [i*KEY_WIDTH +: KEY_WIDTH].
- `cell_values`  in  NUM_CELLS*VALUE_WIDTH  flattened cell value outputs, with the same packing.
- `cell_used`  in  NUM_CELLS  per-cell used flags.
- `read_op`  out  NUM_CELLS  one-hot read strobe to the cells.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_hit`  out  1  key found.
- `resp_value`  out  VALUE_WIDTH  value of the matching cell; 0 on a miss.
- `resp_index`  out  IDX_WIDTH  index of the matching cell; 0 on a miss.

## Operation
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`, latch `req_key`.
  - If the latched key is 0 (reserved "unused" marker), go to RESP as a miss.
  - Otherwise set `idx`=0 and go to SCAN.
- SCAN (one cell per cycle, `req_ready`=0):
  - Match when `cell_used[idx]` is 1 and `cell_keys[idx]` equals the latched key.
  - On a match: register `resp_hit`=1, `resp_value`=`cell_values[idx]` and `resp_index`=`idx`. Set `read_op` = one-hot(`idx`). Go to RESP.
  - No match and `idx`==`NUM_CELLS-1`: register a miss (hit=0, value=0, index=0). Go to RESP.
  - Otherwise: `idx`++.
- RESP:
  - `resp_valid`=1; hit/value/index are held stable until the response is accepted.
  - On `resp_ready`, go to IDLE.
- Duplicate keys: the lowest matching index wins, because the scan is ascending and stops at the first match.
- Cell inputs are sampled live during SCAN. The value returned is the one present in the cycle the match was detected.
- `read_op` is a registered, one-cycle pulse, high only in the first RESP cycle of a hit. It is 0 in all other cycles and on every miss.
- `idx` never exceeds `NUM_CELLS-1`; there is no wrap-around.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_hit`=0, `resp_value`=0, `resp_index`=0, `read_op`=0, `idx`=0.
- Requests presented while `rst` is high are ignored.
- Let E be the accept edge.
  - Hit at cell i: `resp_valid` rises at edge E+i+2.
  - Miss: `resp_valid` rises at edge E+NUM_CELLS+1.
  - Key 0: `resp_valid` rises at edge E+1.
- Response handshake completes on an edge with `resp_valid && resp_ready`.
  - `resp_valid` drops and `req_ready` rises at that edge.
  - The next request can be accepted at the following edge.
  - There is no back-to-back accept in the same cycle as a response.
- `resp_ready` held high before RESP adds no cycles.
- Response data must not change while `resp_valid`=1 and `resp_ready`=0.
- Reset asserted mid-SCAN or mid-RESP aborts immediately: outputs go to reset values and no response is issued.

## Test plan
- Cells 0..7 hold keys 0x11..0x18, all used, value of cell i = 0xA0+i. GET 0x14 -> `resp_valid` at E+5, hit=1, index=3, value=0xA3. `read_op`=8'b0000_1000 for exactly one cycle.
- GET 0x55 (absent) -> `resp_valid` at E+9 (NUM_CELLS=8), hit=0, value=0, index=0, `read_op` stays 0.
- Cells 2 and 6 both hold key 0x33 with values 0x22 and 0x66 -> hit, index=2, value=0x22.
- Cell 1 has key 0x42 but used=0 -> GET 0x42 is a miss. GET 0x00 -> miss at E+1 with no scan.
- Hit response with `resp_ready` held low for 4 cycles -> hit/value/index stable and `read_op` pulsed once. `req_ready`=0 and new `req_valid` is ignored until the handshake completes.
- Assert `rst` at SCAN idx=3 -> `resp_valid` never rises, `req_ready`=1 after release, and a subsequent GET 0x11 hits index 0 at E+2.
